// File: rtl/trace_pkg.sv
// Shared types for the trace commit sink: the buffered retirement record,
// the frame beat and FSM enums, and helpers that walk a record's frame.
package trace_pkg;

    localparam logic [7:0] TRACE_SYNC = 8'hA5;
    localparam int         HDR_SEQ_W  = 14;

    typedef enum logic [2:0] {
        HDR, PC, INSTR, REG_DATA, MEM_ADDR, MEM_DATA, FPU_FLAGS
    } beat_e;

    typedef enum logic {IDLE, SEND} trace_state_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [4:0]           reg_addr;
        logic [31:0]          reg_data;
        logic                 is_load;
        logic                 is_store;
        logic                 is_float;
        logic [1:0]           mem_size;
        logic [31:0]          mem_addr;
        logic [31:0]          mem_data;
        logic [4:0]           fpu_flags;
        logic [HDR_SEQ_W-1:0] seq;
    } trace_rec_t;

    // Optional beats are skipped according to the record's own type bits.
    function automatic beat_e next_beat(beat_e b, trace_rec_t r);
        beat_e n;
        case (b)
            HDR:      n = PC;
            PC:       n = INSTR;
            INSTR:    n = REG_DATA;
            REG_DATA: n = (r.is_load || r.is_store) ? MEM_ADDR : (r.is_float ? FPU_FLAGS : HDR);
            MEM_ADDR: n = MEM_DATA;
            MEM_DATA: n = r.is_float ? FPU_FLAGS : HDR;
            default:  n = HDR;
        endcase
        return n;
    endfunction

    function automatic logic is_last_beat(beat_e b, trace_rec_t r);
        logic l;
        case (b)
            REG_DATA:  l = !(r.is_load || r.is_store) && !r.is_float;
            MEM_DATA:  l = !r.is_float;
            FPU_FLAGS: l = 1'b1;
            default:   l = 1'b0;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] beat_word(beat_e b, trace_rec_t r);
        logic [31:0] w;
        case (b)
            HDR:       w = {TRACE_SYNC, r.reg_addr, r.is_load, r.is_store, r.is_float,
                            r.mem_size, r.seq};
            PC:        w = r.pc;
            INSTR:     w = r.instr;
            REG_DATA:  w = r.reg_data;
            MEM_ADDR:  w = r.mem_addr;
            MEM_DATA:  w = r.mem_data;
            FPU_FLAGS: w = {27'd0, r.fpu_flags};
            default:   w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/trace_commit_sink_if.sv
// Retirement record bundle driven by the write-back stage's tracer port.
interface tracer_interface;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        is_load;
    logic        is_store;
    logic        is_float;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  fpu_flags;

    modport master (output valid, pc, instr, reg_addr, reg_data, is_load, is_store,
                           is_float, mem_size, mem_addr, mem_data, fpu_flags);
    modport sink   (input  valid, pc, instr, reg_addr, reg_data, is_load, is_store,
                           is_float, mem_size, mem_addr, mem_data, fpu_flags);
    modport slave  (input  valid, pc, instr, reg_addr, reg_data, is_load, is_store,
                           is_float, mem_size, mem_addr, mem_data, fpu_flags);
endinterface

// File: rtl/trace_rec_fifo.sv
// Record FIFO; a push while full is still accepted when the head pops in the
// same cycle, because the freed slot is the one being written.
module trace_rec_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  trace_rec_t               i_data,
    input  logic                     i_pop,
    output trace_rec_t               o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_accept
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    trace_rec_t    r_mem [DEPTH];
    logic          w_do_pop;

    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign w_do_pop = i_pop && !o_empty;
    assign o_accept = i_push && (!o_full || w_do_pop);
    assign o_level  = r_level;
    assign o_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (o_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({o_accept, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (o_accept) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/trace_commit_sink.sv
// Captures retirement records into a FIFO and serializes each into a 4-7 word
// frame on a valid/ready stream, with sequence stamping and a drop counter.
module trace_commit_sink
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 14,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    tracer_interface.sink          tracer_if_i,
    input  logic                   trace_en_i,
    output logic [31:0]            trace_data_o,
    output logic                   trace_valid_o,
    output logic                   trace_last_o,
    input  logic                   trace_ready_i,
    output logic [DROP_W-1:0]      drop_count_o,
    output logic [$clog2(DEPTH):0] fifo_level_o
);
    localparam int LW = $clog2(DEPTH) + 1;

    trace_state_e      r_state;
    beat_e             r_beat;
    logic [SEQ_W-1:0]  r_seq;
    logic [DROP_W-1:0] r_drop;

    trace_rec_t        w_rec_in;
    trace_rec_t        w_head;
    logic [LW-1:0]     w_level;
    logic              w_capture, w_full, w_empty, w_accept;
    logic              w_last, w_hs, w_pop, w_goes_empty;

    always_comb begin
        w_rec_in           = '0;
        w_rec_in.pc        = tracer_if_i.pc;
        w_rec_in.instr     = tracer_if_i.instr;
        w_rec_in.reg_addr  = tracer_if_i.reg_addr;
        w_rec_in.reg_data  = tracer_if_i.reg_data;
        w_rec_in.is_load   = tracer_if_i.is_load;
        w_rec_in.is_store  = tracer_if_i.is_store;
        w_rec_in.is_float  = tracer_if_i.is_float;
        w_rec_in.mem_size  = tracer_if_i.mem_size;
        w_rec_in.mem_addr  = tracer_if_i.mem_addr;
        w_rec_in.mem_data  = tracer_if_i.mem_data;
        w_rec_in.fpu_flags = tracer_if_i.fpu_flags;
        w_rec_in.seq       = HDR_SEQ_W'(r_seq);
    end

    assign w_capture    = tracer_if_i.valid && trace_en_i;
    assign w_last       = is_last_beat(r_beat, w_head);
    assign w_hs         = (r_state == SEND) && trace_ready_i;
    assign w_pop        = w_hs && w_last;
    assign w_goes_empty = (w_level == LW'(1)) && !w_accept;

    trace_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_capture),
        .i_data   (w_rec_in),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_level  (w_level),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_accept (w_accept)
    );

    // Back-to-back frames restart at HDR on the last handshake with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= HDR;
            r_seq   <= '0;
            r_drop  <= '0;
        end else begin
            if (w_capture) r_seq <= r_seq + 1'b1;
            if (w_capture && !w_accept && (r_drop != '1)) r_drop <= r_drop + 1'b1;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= SEND;
                        r_beat  <= HDR;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_beat <= HDR;
                            if (w_goes_empty) r_state <= IDLE;
                        end else begin
                            r_beat <= next_beat(r_beat, w_head);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        trace_valid_o = (r_state == SEND);
        trace_data_o  = '0;
        trace_last_o  = 1'b0;
        if (trace_valid_o) begin
            trace_data_o = beat_word(r_beat, w_head);
            trace_last_o = w_last;
        end
    end

    assign drop_count_o = r_drop;
    assign fifo_level_o = w_level;

endmodule
